// File: rtl/clkbuf_branch_sequencer.sv
// Staggered enable sequencer for gated clock-tree branches: one branch switches per
// transition, followed by a programmable settle window before the next may start.
module clkbuf_branch_sequencer #(
  parameter int N_BRANCH = 4,
  parameter int STAGGER  = 3
) (
  input  logic                CLK,
  input  logic                RN,
  input  logic [N_BRANCH-1:0] REQ,
  input  logic                TE,
  output logic [N_BRANCH-1:0] EN,
  output logic [N_BRANCH-1:0] ACK,
  output logic                BUSY,
  output logic                dbg_state
);

  localparam int GW = $clog2(N_BRANCH);
  localparam int CW = $clog2(STAGGER + 1);
  localparam logic [GW-1:0] LAST_IDX = GW'(N_BRANCH - 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(STAGGER - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  // Handshake: REQ[i] is a level; ACK[i] follows it high only after the branch clock
  // has run a full settle window, and drops on the very edge EN[i] is removed.
  state_t              state, state_nx;
  logic [N_BRANCH-1:0] en_r, en_nx;
  logic [N_BRANCH-1:0] ack_r, ack_nx;
  logic [GW-1:0]       rr_ptr, rr_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [GW-1:0]       g_idx, g_nx;
  logic                g_dir, dir_nx;

  logic [N_BRANCH-1:0] pending;
  logic                found;
  logic [GW-1:0]       grant;
  logic [GW-1:0]       cand;
  int                  arb_j;

  assign pending = REQ ^ en_r;

  // Round-robin search: first pending index at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    grant = rr_ptr;
    cand  = rr_ptr;
    arb_j = 0;
    for (int off = 0; off < N_BRANCH; off++) begin
      arb_j = int'(rr_ptr) + off;
      if (arb_j >= N_BRANCH) arb_j = arb_j - N_BRANCH;
      cand = GW'(arb_j);
      if (!found && pending[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  always_comb begin
    state_nx = state;
    en_nx    = en_r;
    ack_nx   = ack_r;
    rr_nx    = rr_ptr;
    cnt_nx   = cnt;
    g_nx     = g_idx;
    dir_nx   = g_dir;
    case (state)
      IDLE: begin
        if (found) begin
          en_nx[grant] = REQ[grant];
          if (!REQ[grant]) ack_nx[grant] = 1'b0;
          cnt_nx   = CNT_LOAD;
          rr_nx    = (grant == LAST_IDX) ? '0 : grant + 1'b1;
          g_nx     = grant;
          dir_nx   = REQ[grant];
          state_nx = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else begin
          if (g_dir) ack_nx[g_idx] = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state  <= IDLE;
      en_r   <= '0;
      ack_r  <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
      g_idx  <= '0;
      g_dir  <= 1'b0;
    end else begin
      state  <= state_nx;
      en_r   <= en_nx;
      ack_r  <= ack_nx;
      rr_ptr <= rr_nx;
      cnt    <= cnt_nx;
      g_idx  <= g_nx;
      g_dir  <= dir_nx;
    end
  end

  // Test enable overrides the gating cells only; sequencing state is untouched.
  assign EN        = en_r | {N_BRANCH{TE}};
  assign ACK       = ack_r;
  assign BUSY      = (state == SETTLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_clkbuf_branch_sequencer.sv
// Bench for clkbuf_branch_sequencer: directed scenarios plus random REQ/TE traffic,
// checked every cycle against a timestamp-based model of the transition schedule.
module tb_clkbuf_branch_sequencer;

  localparam int N = 4;
  localparam int S = 3;
  localparam int W = 2 * N + 1;

  logic         CLK;
  logic         RN;
  logic [N-1:0] REQ;
  logic         TE;
  logic [N-1:0] EN;
  logic [N-1:0] ACK;
  logic         BUSY;
  logic         dbg_state;

  int vectors    = 0;
  int miscompares = 0;

  logic [W-1:0] exp_q[$];

  // Reference model: each transition is a timestamp; the settle window and the
  // acknowledge are derived from that timestamp rather than from a counter.
  logic [N-1:0] m_en;
  logic [N-1:0] m_ack;
  int           m_rr;
  int           edge_no;
  int           next_ok;
  int           grant_edge;
  int           ack_edge;
  int           ack_idx;

  clkbuf_branch_sequencer #(.N_BRANCH(N), .STAGGER(S)) dut (
    .CLK       (CLK),
    .RN        (RN),
    .REQ       (REQ),
    .TE        (TE),
    .EN        (EN),
    .ACK       (ACK),
    .BUSY      (BUSY),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic reset_model();
    m_en       = '0;
    m_ack      = '0;
    m_rr       = 0;
    edge_no    = 0;
    next_ok    = 1;
    grant_edge = -100;
    ack_edge   = -1;
    ack_idx    = 0;
  endtask

  task automatic model_edge();
    logic [N-1:0] pend;
    int g;
    edge_no++;
    if (edge_no == ack_edge) m_ack[ack_idx] = 1'b1;
    if (edge_no >= next_ok) begin
      pend = REQ ^ m_en;
      g = -1;
      for (int off = 0; off < N; off++) begin
        if (g < 0 && pend[(m_rr + off) % N]) g = (m_rr + off) % N;
      end
      if (g >= 0) begin
        m_en[g] = REQ[g];
        if (!REQ[g]) m_ack[g] = 1'b0;
        else begin
          ack_edge = edge_no + S;
          ack_idx  = g;
        end
        grant_edge = edge_no;
        next_ok    = edge_no + S + 1;
        m_rr       = (g + 1) % N;
      end
    end
  endtask

  // Scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] e;
    logic         exp_busy;
    exp_busy = (edge_no >= grant_edge) && (edge_no <= grant_edge + S - 1);
    exp_q.push_back({m_en | {N{TE}}, m_ack, exp_busy});
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("en",   32'(EN),   32'(e[W-1 -: N]));
      check("ack",  32'(ACK),  32'(e[N:1]));
      check("busy", 32'(BUSY), 32'(e[0]));
      check("ack_implies_en", 32'(ACK & ~dut.en_r), 32'd0);
    end
  endtask

  // Drivers
  task automatic step(input logic [N-1:0] r, input logic t);
    REQ = r;
    TE  = t;
    @(posedge CLK);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic rst_pulse();
    RN = 1'b0;
    #1;
    check("rst_en",   32'(EN),   32'd0);
    check("rst_ack",  32'(ACK),  32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    #1;
    RN = 1'b1;
    reset_model();
  endtask

  initial begin
    logic [N-1:0] r;
    logic         t;
    RN  = 1'b0;
    REQ = '0;
    TE  = 1'b0;
    reset_model();
    repeat (2) @(posedge CLK);
    #1;
    check("por_en",   32'(EN),   32'd0);
    check("por_ack",  32'(ACK),  32'd0);
    check("por_busy", 32'(BUSY), 32'd0);
    #2;
    RN = 1'b1;

    // Single on-transition
    step(4'b0001, 1'b0);
    check("single_en", 32'(EN), 32'h1);
    check("single_busy", 32'(BUSY), 32'd1);
    for (int k = 2; k <= 5; k++) begin
      step(4'b0001, 1'b0);
      if (k == 3) check("single_ack_early", 32'(ACK), 32'h0);
      if (k == 4) check("single_ack", 32'(ACK), 32'h1);
    end

    // Burst arbitration
    rst_pulse();
    for (int k = 1; k <= 16; k++) begin
      step(4'b1111, 1'b0);
      case (k)
        1:  check("burst_en1",  32'(EN), 32'h1);
        5:  check("burst_en5",  32'(EN), 32'h3);
        9:  check("burst_en9",  32'(EN), 32'h7);
        13: check("burst_en13", 32'(EN), 32'hf);
        16: check("burst_ack16", 32'(ACK), 32'hf);
        default: ;
      endcase
    end

    // Round-robin wrap from rr_ptr=3
    rst_pulse();
    repeat (13) step(4'b0111, 1'b0);
    step(4'b1110, 1'b0);
    check("rr_first3", 32'(EN), 32'hf);
    repeat (4) step(4'b1110, 1'b0);
    check("rr_then0_en",  32'(EN),  32'he);
    check("rr_then0_ack", 32'(ACK), 32'he);
    repeat (3) step(4'b1110, 1'b0);
    step(4'b1000, 1'b0);
    check("rr_ptr1", 32'(EN), 32'hc);
    repeat (12) step(4'b1000, 1'b0);

    // Off then re-raise during the off settle window
    rst_pulse();
    repeat (5) step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    check("off_en",  32'(EN),  32'h0);
    check("off_ack", 32'(ACK), 32'h0);
    repeat (4) step(4'b0001, 1'b0);
    check("retoggle_en", 32'(EN), 32'h1);
    repeat (2) step(4'b0001, 1'b0);
    check("retoggle_ack_early", 32'(ACK), 32'h0);
    step(4'b0001, 1'b0);
    check("retoggle_ack", 32'(ACK), 32'h1);

    // Reset in the middle of a settle window
    rst_pulse();
    repeat (5) step(4'b0011, 1'b0);
    check("mid_en",   32'(EN),   32'h3);
    check("mid_ack",  32'(ACK),  32'h1);
    check("mid_busy", 32'(BUSY), 32'd1);
    rst_pulse();
    for (int k = 1; k <= 10; k++) begin
      step(4'b0011, 1'b0);
      if (k == 1) check("mid_re_en1", 32'(EN), 32'h1);
      if (k == 5) check("mid_re_en5", 32'(EN), 32'h3);
    end

    // Test enable
    rst_pulse();
    step(4'b0000, 1'b0);
    TE = 1'b1;
    #1;
    check("te_en",   32'(EN),   32'hf);
    check("te_ack",  32'(ACK),  32'h0);
    check("te_busy", 32'(BUSY), 32'd0);
    repeat (3) step(4'b0000, 1'b1);
    TE = 1'b0;
    #1;
    check("te_off_en", 32'(EN), 32'h0);

    // Random traffic
    r = '0;
    t = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, (1 << N) - 1));
      t = ($urandom_range(0, 15) == 0);
      step(r, t);
      if ($urandom_range(0, 149) == 0) rst_pulse();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
